// File: rtl/matmul_apb_regfile.sv
// APB4 completer for the matmul calculator: CONTROL/STATUS registers plus
// operand memories A and B, with wait states, byte strobes, busy write
// lockout, sticky DONE and engine-side combinational operand read ports.
module matmul_apb_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 16,
  parameter int N_SP        = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [DATA_WIDTH/8-1:0]       pstrb_i,
  input  logic [DATA_WIDTH-1:0]         pwdata_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [DATA_WIDTH-1:0]         prdata_o,
  output logic                          busy_o,
  output logic                          start_o,
  output logic [1:0]                    mode_o,
  output logic [$clog2(N_SP)-1:0]       sp_sel_o,
  input  logic                          engine_busy_i,
  input  logic                          engine_done_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]  opa_raddr_i,
  output logic [DATA_WIDTH-1:0]         opa_rdata_o,
  input  logic [$clog2(MEM_DEPTH)-1:0]  opb_raddr_i,
  output logic [DATA_WIDTH-1:0]         opb_rdata_o
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int SPW = $clog2(N_SP);
  localparam int WA  = ADDR_WIDTH - 2;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                               state_q, state_d;
  logic [3:0]                           cnt_q, cnt_d;
  logic [WA-1:0]                        addr_q, addr_d;
  logic                                 wr_q, wr_d;
  logic [NB-1:0]                        strb_q, strb_d;
  logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
  logic [1:0]                           mode_q, mode_d;
  logic [SPW-1:0]                       sp_q, sp_d;
  logic                                 done_q, done_d;
  logic                                 pend_q, pend_d;
  logic                                 start_q, start_d;
  logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem_a_q, mem_a_d, mem_b_q, mem_b_d;

  // Byte offset bits never take part in decode.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^paddr_i[1:0];

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    byte_merge = old_w;
    for (int k = 0; k < NB; k++)
      if (be[k]) byte_merge[8*k +: 8] = new_w[8*k +: 8];
  endfunction

  logic                  sel_ctrl, sel_stat, sel_a, sel_b, in_rng;
  logic                  locked, err, commit;
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] ctrl_word, rd_word;

  assign busy_o = pend_q | engine_busy_i;

  // Decode the latched address and build the read word for the current access.
  always_comb begin
    in_rng    = ({{(DATA_WIDTH-6){1'b0}}, addr_q[5:0]} < DATA_WIDTH'(MEM_DEPTH));
    sel_ctrl  = (addr_q == '0);
    sel_stat  = (addr_q == WA'(1));
    sel_a     = (addr_q[WA-1:6] == (ADDR_WIDTH-8)'(1)) && in_rng;
    sel_b     = (addr_q[WA-1:6] == (ADDR_WIDTH-8)'(2)) && in_rng;
    idx       = addr_q[AW-1:0];
    locked    = wr_q && busy_o && (sel_ctrl || sel_a || sel_b);
    err       = !(sel_ctrl || sel_stat || sel_a || sel_b) || locked;
    ctrl_word = '0;
    ctrl_word[2:1]     = mode_q;
    ctrl_word[8 +: SPW] = sp_q;
    rd_word   = '0;
    if (sel_ctrl)      rd_word = ctrl_word;
    else if (sel_stat) rd_word[1:0] = {done_q, busy_o};
    else if (sel_a)    rd_word = mem_a_q[idx];
    else if (sel_b)    rd_word = mem_b_q[idx];
  end

  assign pready_o  = (state_q == ACCESS) && psel_i && penable_i && (cnt_q == 4'd0);
  assign commit    = pready_o && wr_q && !err;
  assign pslverr_o = pready_o && err;
  assign prdata_o  = (pready_o && !wr_q && !err) ? rd_word : '0;

  assign start_o     = start_q;
  assign mode_o      = mode_q;
  assign sp_sel_o    = sp_q;
  assign opa_rdata_o = mem_a_q[opa_raddr_i];
  assign opb_rdata_o = mem_b_q[opb_raddr_i];

  // Transfer sequencing, write commit, start/busy handshake and DONE tracking.
  always_comb begin
    logic [DATA_WIDTH-1:0] cw;
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    sp_d    = sp_q;
    done_d  = done_q;
    pend_d  = pend_q;
    start_d = 1'b0;
    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    cw      = byte_merge(ctrl_word, wdata_q, strb_q);

    case (state_q)
      IDLE: if (psel_i && !penable_i) begin
        state_d = ACCESS;
        addr_d  = paddr_i[ADDR_WIDTH-1:2];
        wr_d    = pwrite_i;
        strb_d  = pstrb_i;
        wdata_d = pwdata_i;
        cnt_d   = 4'(WAIT_STATES);
      end
      default: begin
        if (!psel_i)                 state_d = IDLE;
        else if (penable_i) begin
          if (cnt_q != 4'd0)         cnt_d   = cnt_q - 4'd1;
          else                       state_d = IDLE;
        end
      end
    endcase

    // The engine has picked up the start once it reports busy.
    if (engine_busy_i) pend_d = 1'b0;

    if (commit) begin
      if (sel_ctrl) begin
        mode_d = cw[2:1];
        sp_d   = cw[8 +: SPW];
        if (strb_q[0] && wdata_q[0]) begin
          pend_d  = 1'b1;
          start_d = 1'b1;
          done_d  = 1'b0;
        end
      end
      if (sel_stat && strb_q[0] && wdata_q[1]) done_d = 1'b0;
      if (sel_a) mem_a_d[idx] = byte_merge(mem_a_q[idx], wdata_q, strb_q);
      if (sel_b) mem_b_d[idx] = byte_merge(mem_b_q[idx], wdata_q, strb_q);
    end

    // A completion arriving with a clear keeps DONE set.
    if (engine_done_i) done_d = 1'b1;
  end

  // State registers; reset drops any in-flight transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      sp_q    <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      mem_a_q <= '0;
      mem_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      sp_q    <= sp_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      mem_a_q <= mem_a_d;
      mem_b_q <= mem_b_d;
    end
  end

endmodule

// File: doc/matmul_apb_regfile.md
Name: matmul_apb_regfile

Overview:
- Parametrised APB4 completer and operand store for the matmul calculator; sits between the APB bus and the matmul engine.
- Decodes a control/status register pair and two operand memories (A, B).
- Adds what the basic slave lacks: configurable wait states, byte-strobe writes, busy write-lockout with pslverr, sticky done, and scratchpad/mode selection.
- Drives start/mode to the engine and serves engine-side operand reads.

Parameters:
- DATA_WIDTH, 32, APB data width and operand word width (multiple of 8).
- ADDR_WIDTH, 16, APB address width.
- MEM_DEPTH, 16, words per operand memory (power of two, max 64).
- N_SP, 4, number of engine scratchpads selectable in CONTROL (power of two, at least 2).
- WAIT_STATES, 0, extra access cycles before pready_o (0..15).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1 = write.
- pstrb_i  in  DATA_WIDTH/8  write byte strobes.
- pwdata_i  in  DATA_WIDTH  write data.
- paddr_i  in  ADDR_WIDTH  byte address.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error, valid with pready_o.
- prdata_o  out  DATA_WIDTH  read data, valid with pready_o.
- busy_o  out  1  engine running or start pending.
- start_o  out  1  one-cycle engine start pulse.
- mode_o  out  2  CONTROL.MODE.
- sp_sel_o  out  $clog2(N_SP)  CONTROL.SP.
- engine_busy_i  in  1  engine active.
- engine_done_i  in  1  one-cycle completion pulse.
- opa_raddr_i  in  $clog2(MEM_DEPTH)  engine read address, memory A.
- opa_rdata_o  out  DATA_WIDTH  memory A word, combinational.
- opb_raddr_i  in  $clog2(MEM_DEPTH)  engine read address, memory B.
- opb_rdata_o  out  DATA_WIDTH  memory B word, combinational.

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_ni.
  - All registers and memories are zero; FSM enters IDLE.
  - pready_o, pslverr_o, start_o, busy_o and prdata_o are 0; mode_o and sp_sel_o are 0.
- Address map (word aligned; paddr_i[1:0] ignored):
  - 0x000 CONTROL RW: bit0 START (write-1 pulses start, always reads 0); bits[2:1] MODE; bits[8+:log2 N_SP] SP.
  - 0x004 STATUS: bit0 busy_o (RO); bit1 DONE (sticky, write-1-clears).
  - 0x100 + 4*i: memory A word i, for i < MEM_DEPTH.
  - 0x200 + 4*i: memory B word i, for i < MEM_DEPTH.
  - Any other address: pslverr_o=1; no state change; prdata_o=0.
- FSM:
  - IDLE → ACCESS on psel_i & !penable_i (setup). Latch paddr_i, pwrite_i, pstrb_i and pwdata_i; load wait counter = WAIT_STATES.
  - ACCESS with penable_i: if counter ≠ 0, decrement it. If counter = 0, assert pready_o combinationally, commit the write on that clock edge, then go to IDLE.
  - Back-to-back transfers are allowed: the next setup may follow immediately in the cycle after pready_o.
  - ACCESS with psel_i=0 (protocol abort): return to IDLE with no commit.
- Latency: with WAIT_STATES=W, pready_o rises W cycles after the first penable_i cycle (W=0 gives zero-wait).
- pslverr_o and prdata_o are driven only while pready_o=1; otherwise both are 0.
- Writes: byte lane k updates only if pstrb_i[k]=1.
  - pstrb_i=0 is a legal write with no effect.
  - Writes to STATUS affect only the DONE W1C bit.
  - pstrb_i is ignored on reads.
- Busy lockout: while busy_o=1, writes to CONTROL, memory A or memory B return pslverr_o=1 with no update. Reads and STATUS W1C are always allowed.
- Start:
  - A committed CONTROL write with bit0=1 and pstrb_i[0]=1 (not locked out) sets start_pending.
  - start_o pulses for exactly one cycle, the cycle after the commit.
  - The same write also clears DONE.
  - busy_o = start_pending | engine_busy_i; start_pending clears on the first cycle engine_busy_i=1.
- DONE: set on engine_done_i. If engine_done_i coincides with a W1C write, set wins.
- Engine reads of the memories are combinational and concurrent with APB accesses. A same-cycle APB write is visible to the engine on the next cycle.
- Reset asserted mid-transfer: immediate return to reset values; the pending write is lost.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x104 with strb=0xF, then read 0x104 → pready_o in the first access cycle; prdata_o=0xDEADBEEF; opa_raddr_i=1 gives opa_rdata_o=0xDEADBEEF.
- WAIT_STATES=3: read 0x200 → pready_o low for 3 access cycles, high on the 4th; prdata_o=0.
- Byte strobes: write 0x11223344 to 0x100 with strb=0xF, then 0xAABBCCDD with strb=0x5 → readback 0x11BB33DD.
- Start and lockout:
  - Write CONTROL=0x0000_0103 → start_o one-cycle pulse; mode_o=1; sp_sel_o=1; busy_o=1.
  - Hold engine_busy_i=1 and write 0x100 → pslverr_o=1, data unchanged.
  - Drop engine_busy_i and pulse engine_done_i → STATUS reads 0x2; writing 0x2 to STATUS clears it to 0x0.
- Illegal address: read 0x300 and write 0x008 → pslverr_o=1; prdata_o=0; no register change.
- Reset: assert rst_ni=0 during a write access cycle with WAIT_STATES=2 → pready_o=0 at once; after release the target word reads 0.
